// File: rtl/cursor_ctrl_if.sv
// Command/status bundle between the terminal command decoder and cursor_ctrl.
// slave = cursor controller side, master = command source / scroll consumer side.
interface cursor_ctrl_if #(
    parameter int unsigned ROW_W = 5,
    parameter int unsigned COL_W = 6
);
    logic             i_cmd_home;
    logic             i_cmd_goto;
    logic [ROW_W-1:0] i_goto_row;
    logic [COL_W-1:0] i_goto_col;
    logic             i_cmd_lf;
    logic             i_cmd_cr;
    logic             i_cmd_bs;
    logic             i_cmd_tab;
    logic             i_cmd_advance;
    logic             i_scroll_ack;
    logic [ROW_W-1:0] o_row;
    logic [COL_W-1:0] o_col;
    logic             o_last_row;
    logic             o_last_col;
    logic             o_scroll_req;
    logic             o_busy;

    modport slave (
        input  i_cmd_home, i_cmd_goto, i_goto_row, i_goto_col, i_cmd_lf,
               i_cmd_cr, i_cmd_bs, i_cmd_tab, i_cmd_advance, i_scroll_ack,
        output o_row, o_col, o_last_row, o_last_col, o_scroll_req, o_busy
    );

    modport master (
        output i_cmd_home, i_cmd_goto, i_goto_row, i_goto_col, i_cmd_lf,
               i_cmd_cr, i_cmd_bs, i_cmd_tab, i_cmd_advance, i_scroll_ack,
        input  o_row, o_col, o_last_row, o_last_col, o_scroll_req, o_busy
    );
endinterface

// File: rtl/cursor_ctrl.sv
// Cursor row/column controller with automargin and req/ack scroll handshake.
// Optional tab command compiled in with `define CURSOR_TAB_EN.
module cursor_ctrl #(
    parameter int unsigned COLS      = 60,
    parameter int unsigned ROWS      = 17,
    parameter int unsigned COL_W     = 6,
    parameter int unsigned ROW_W     = 5,
    parameter int unsigned SCROLL    = 1,
    parameter int unsigned TAB_WIDTH = 8
) (
    input logic         i_clk,
    input logic         i_rst,
    cursor_ctrl_if.slave bus
);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    typedef enum logic {
        IDLE,
        SCROLL_WAIT
    } state_t;

    state_t           state, state_nxt;
    logic [ROW_W-1:0] row_q, row_nxt;
    logic [COL_W-1:0] col_q, col_nxt;
    logic             req_q;
    logic [ROW_W-1:0] goto_row_c;
    logic [COL_W-1:0] goto_col_c;

    assign goto_row_c = (bus.i_goto_row > LAST_ROW) ? LAST_ROW : bus.i_goto_row;
    assign goto_col_c = (bus.i_goto_col > LAST_COL) ? LAST_COL : bus.i_goto_col;

`ifdef CURSOR_TAB_EN
    // Extra bit so the next stop past a full-width column range cannot wrap to 0.
    logic [COL_W:0]   tab_sum_c;
    logic [COL_W-1:0] tab_col_c;

    assign tab_sum_c = {1'b0, col_q | COL_W'(TAB_WIDTH - 1)} + (COL_W+1)'(1);
    assign tab_col_c = (tab_sum_c > {1'b0, LAST_COL}) ? LAST_COL : tab_sum_c[COL_W-1:0];
`else
    wire unused_tab = bus.i_cmd_tab ^ TAB_WIDTH[0];
`endif

    always_comb begin
        state_nxt = state;
        row_nxt   = row_q;
        col_nxt   = col_q;
        unique case (state)
            IDLE: begin
                if (bus.i_cmd_home) begin
                    row_nxt = '0;
                    col_nxt = '0;
                end else if (bus.i_cmd_goto) begin
                    row_nxt = goto_row_c;
                    col_nxt = goto_col_c;
                end else if (bus.i_cmd_lf) begin
                    if (row_q != LAST_ROW)  row_nxt   = row_q + ROW_W'(1);
                    else if (SCROLL != 0)   state_nxt = SCROLL_WAIT;
                end else if (bus.i_cmd_cr) begin
                    col_nxt = '0;
                end else if (bus.i_cmd_bs) begin
                    if (col_q != '0) col_nxt = col_q - COL_W'(1);
`ifdef CURSOR_TAB_EN
                end else if (bus.i_cmd_tab) begin
                    col_nxt = tab_col_c;
`endif
                end else if (bus.i_cmd_advance) begin
                    if (col_q != LAST_COL) begin
                        col_nxt = col_q + COL_W'(1);
                    end else begin
                        // Automargin: wrap to column 0 and line-feed.
                        col_nxt = '0;
                        if (row_q != LAST_ROW) row_nxt   = row_q + ROW_W'(1);
                        else if (SCROLL != 0)  state_nxt = SCROLL_WAIT;
                    end
                end
            end
            SCROLL_WAIT: begin
                if (bus.i_scroll_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            row_q <= LAST_ROW;
            col_q <= '0;
            req_q <= 1'b0;
        end else begin
            state <= state_nxt;
            row_q <= row_nxt;
            col_q <= col_nxt;
            req_q <= (state_nxt == SCROLL_WAIT);
        end
    end

    assign bus.o_row        = row_q;
    assign bus.o_col        = col_q;
    assign bus.o_last_row   = (row_q == LAST_ROW);
    assign bus.o_last_col   = (col_q == LAST_COL);
    assign bus.o_scroll_req = req_q;
    assign bus.o_busy       = (state == SCROLL_WAIT);
endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed bench for cursor_ctrl: default instance plus a SCROLL=0 clamp instance.
module tb_cursor_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cursor_ctrl_if #(.ROW_W(5), .COL_W(6)) bus  ();
    cursor_ctrl_if #(.ROW_W(5), .COL_W(6)) bus2 ();

    cursor_ctrl u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    cursor_ctrl #(.SCROLL(0)) u_clamp (
        .i_clk (clk),
        .i_rst (rst2),
        .bus   (bus2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_cmds();
        bus.i_cmd_home    = 1'b0;  bus2.i_cmd_home    = 1'b0;
        bus.i_cmd_goto    = 1'b0;  bus2.i_cmd_goto    = 1'b0;
        bus.i_cmd_lf      = 1'b0;  bus2.i_cmd_lf      = 1'b0;
        bus.i_cmd_cr      = 1'b0;  bus2.i_cmd_cr      = 1'b0;
        bus.i_cmd_bs      = 1'b0;  bus2.i_cmd_bs      = 1'b0;
        bus.i_cmd_tab     = 1'b0;  bus2.i_cmd_tab     = 1'b0;
        bus.i_cmd_advance = 1'b0;  bus2.i_cmd_advance = 1'b0;
        bus.i_scroll_ack  = 1'b0;  bus2.i_scroll_ack  = 1'b0;
    endtask

    task automatic do_goto(input int r, input int c);
        bus.i_goto_row = 5'(r);
        bus.i_goto_col = 6'(c);
        bus.i_cmd_goto = 1'b1;
        tick();
        bus.i_cmd_goto = 1'b0;
    endtask

    initial begin
        clear_cmds();
        bus.i_goto_row  = '0;  bus.i_goto_col  = '0;
        bus2.i_goto_row = '0;  bus2.i_goto_col = '0;
        rst = 1'b1;
        rst2 = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        rst2 = 1'b0;

        check("rst_row", int'(bus.o_row), 16);
        check("rst_col", int'(bus.o_col), 0);
        check("rst_req", int'(bus.o_scroll_req), 0);
        check("rst_busy", int'(bus.o_busy), 0);
        check("rst_last_row", int'(bus.o_last_row), 1);
        check("rst_last_col", int'(bus.o_last_col), 0);

        // 59 advances reach the last column, the 60th wraps and scrolls
        bus.i_cmd_advance = 1'b1;
        repeat (59) tick();
        check("adv59_col", int'(bus.o_col), 59);
        check("adv59_last_col", int'(bus.o_last_col), 1);
        check("adv59_req", int'(bus.o_scroll_req), 0);
        tick();
        bus.i_cmd_advance = 1'b0;
        check("adv60_row", int'(bus.o_row), 16);
        check("adv60_col", int'(bus.o_col), 0);
        check("adv60_req", int'(bus.o_scroll_req), 1);
        check("adv60_busy", int'(bus.o_busy), 1);
        bus.i_scroll_ack = 1'b1;
        tick();
        bus.i_scroll_ack = 1'b0;
        check("ack_req", int'(bus.o_scroll_req), 0);
        check("ack_busy", int'(bus.o_busy), 0);
        check("ack_row", int'(bus.o_row), 16);
        check("ack_col", int'(bus.o_col), 0);

        do_goto(3, 59);
        check("goto_row", int'(bus.o_row), 3);
        check("goto_col", int'(bus.o_col), 59);
        bus.i_cmd_advance = 1'b1;
        tick();
        bus.i_cmd_advance = 1'b0;
        check("wrap_row", int'(bus.o_row), 4);
        check("wrap_col", int'(bus.o_col), 0);
        check("wrap_req", int'(bus.o_scroll_req), 0);
        do_goto(31, 63);
        check("clamp_row", int'(bus.o_row), 16);
        check("clamp_col", int'(bus.o_col), 59);

        // lf at last row, ack withheld while other commands are ignored
        bus.i_cmd_lf = 1'b1;
        tick();
        bus.i_cmd_lf = 1'b0;
        check("lf_busy", int'(bus.o_busy), 1);
        check("lf_row", int'(bus.o_row), 16);
        check("lf_col", int'(bus.o_col), 59);
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) bus.i_cmd_cr = 1'b1;
            else            bus.i_cmd_advance = 1'b1;
            tick();
            clear_cmds();
            check("wait_busy", int'(bus.o_busy), 1);
            check("wait_col", int'(bus.o_col), 59);
        end
        bus.i_scroll_ack = 1'b1;
        tick();
        bus.i_scroll_ack = 1'b0;
        check("ack2_busy", int'(bus.o_busy), 0);
        check("ack2_col", int'(bus.o_col), 59);
        bus.i_cmd_cr = 1'b1;
        tick();
        bus.i_cmd_cr = 1'b0;
        check("cr_col", int'(bus.o_col), 0);

        // Priority resolution
        bus.i_cmd_home = 1'b1;
        bus.i_cmd_advance = 1'b1;
        bus.i_cmd_lf = 1'b1;
        tick();
        clear_cmds();
        check("home_row", int'(bus.o_row), 0);
        check("home_col", int'(bus.o_col), 0);
        check("home_req", int'(bus.o_scroll_req), 0);
        bus.i_cmd_lf = 1'b1;
        tick();
        bus.i_cmd_lf = 1'b0;
        check("lf1_row", int'(bus.o_row), 1);
        do_goto(0, 10);
        bus.i_cmd_bs = 1'b1;
        bus.i_cmd_advance = 1'b1;
        tick();
        clear_cmds();
        check("bs_col", int'(bus.o_col), 9);
        bus.i_cmd_cr = 1'b1;
        tick();
        bus.i_cmd_cr = 1'b0;
        bus.i_cmd_bs = 1'b1;
        tick();
        bus.i_cmd_bs = 1'b0;
        check("bs0_col", int'(bus.o_col), 0);

        do_goto(0, 5);
        bus.i_cmd_tab = 1'b1;
        bus.i_cmd_advance = 1'b1;
        tick();
        clear_cmds();
`ifdef CURSOR_TAB_EN
        check("tab_adv_col", int'(bus.o_col), 8);
        do_goto(0, 0);
        bus.i_cmd_tab = 1'b1;
        tick();
        check("tab0_col", int'(bus.o_col), 8);
        bus.i_cmd_tab = 1'b0;
        do_goto(0, 57);
        bus.i_cmd_tab = 1'b1;
        tick();
        check("tab57_col", int'(bus.o_col), 59);
        tick();
        check("tab59_col", int'(bus.o_col), 59);
        bus.i_cmd_tab = 1'b0;
`else
        check("tab_adv_col", int'(bus.o_col), 6);
`endif

        // Reset while waiting for the scroll ack
        do_goto(16, 5);
        bus.i_cmd_lf = 1'b1;
        tick();
        bus.i_cmd_lf = 1'b0;
        check("pre_rst_busy", int'(bus.o_busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("wrst_req", int'(bus.o_scroll_req), 0);
        check("wrst_busy", int'(bus.o_busy), 0);
        check("wrst_row", int'(bus.o_row), 16);
        check("wrst_col", int'(bus.o_col), 0);
        bus.i_scroll_ack = 1'b1;
        tick();
        bus.i_scroll_ack = 1'b0;
        check("idle_ack_busy", int'(bus.o_busy), 0);
        check("idle_ack_row", int'(bus.o_row), 16);

        // SCROLL=0 instance clamps at the last row
        bus2.i_cmd_lf = 1'b1;
        tick();
        bus2.i_cmd_lf = 1'b0;
        check("c_lf_row", int'(bus2.o_row), 16);
        check("c_lf_req", int'(bus2.o_scroll_req), 0);
        check("c_lf_busy", int'(bus2.o_busy), 0);
        bus2.i_goto_row = 5'd16;
        bus2.i_goto_col = 6'd59;
        bus2.i_cmd_goto = 1'b1;
        tick();
        bus2.i_cmd_goto = 1'b0;
        bus2.i_cmd_advance = 1'b1;
        tick();
        bus2.i_cmd_advance = 1'b0;
        check("c_adv_row", int'(bus2.o_row), 16);
        check("c_adv_col", int'(bus2.o_col), 0);
        check("c_adv_req", int'(bus2.o_scroll_req), 0);
        tick();
        check("c_idle_req", int'(bus2.o_scroll_req), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
